execute_muldiv_unit: RTL and testbench

Multi-cycle RV32M/RV64M execute-stage functional unit, width-parametrised by XLEN. It sits in the E stage beside the single-cycle ALU and receives the same post-forwarding operands. It performs MUL/MULH/MULHSU/MULHU with an iterative shift-add and DIV/DIVU/REM/REMU with an iterative restoring divide. While an operation is in flight it raises a stall to the hazard unit, and it returns one registered result with a single-cycle done pulse.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/cond_negate.sv | 12 +
 rtl/execute_muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV M-extension encodings and muldiv FSM states
package riscv_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_ITER_MUL = 2'd1,
      MD_ITER_DIV = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/cond_negate.sv
// rtl/cond_negate.sv - two's-complement negate when neg is set
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit for the E stage
module execute_muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            E_md_start,
   input  logic [2:0]      E_md_op,
   input  logic [XLEN-1:0] E_md_src_a,
   input  logic [XLEN-1:0] E_md_src_b,
   input  logic            E_md_flush,
   output logic            E_md_stall,
   output logic            E_md_done,
   output logic [XLEN-1:0] E_md_result
);

   localparam int CW = $clog2(XLEN) + 1;

   md_state_t         state;
   md_op_t            op_q;
   logic              neg_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     cnt;

   logic              sa, sb, neg_in, accept, special;
   logic [XLEN-1:0]   abs_a, abs_b, special_res;

   assign sa = !(E_md_op == 3'd3 || E_md_op[2:0] == 3'd5 || E_md_op == 3'd7) && E_md_src_a[XLEN-1];
   assign sb = (E_md_op == 3'd0 || E_md_op == 3'd1 || E_md_op == 3'd4 || E_md_op == 3'd6)
               && E_md_src_b[XLEN-1];
   assign accept = (state == MD_IDLE) && E_md_start && !E_md_flush;

   always_comb begin
      case (md_op_t'(E_md_op))
         MD_MUL, MD_MULH, MD_DIV: neg_in = sa ^ sb;
         MD_MULHSU, MD_REM:       neg_in = sa;
         default:                 neg_in = 1'b0;
      endcase
   end

   cond_negate #(.WIDTH(XLEN)) u_abs_a (.x(E_md_src_a), .neg(sa), .y(abs_a));
   cond_negate #(.WIDTH(XLEN)) u_abs_b (.x(E_md_src_b), .neg(sb), .y(abs_b));

   // Divide-by-zero and signed overflow resolve without iterating.
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (E_md_op[2]) begin
         if (E_md_src_b == '0) begin
            special     = 1'b1;
            special_res = E_md_op[1] ? E_md_src_a : '1;
         end else if (!E_md_op[0] && E_md_src_a == {1'b1, {(XLEN-1){1'b0}}} && E_md_src_b == '1) begin
            special     = 1'b1;
            special_res = E_md_op[1] ? '0 : E_md_src_a;
         end
      end
   end

   // One adder: MUL adds b into the high half, DIV trial-subtracts b from the shifted remainder.
   logic [XLEN:0]     add_x, add_y;
   logic              add_cin, no_borrow;
   logic [XLEN+1:0]   add_sum;
   logic [2*XLEN-1:0] acc_next, fix_in, fix_out;
   logic [XLEN-1:0]   iter_res;

   always_comb begin
      if (state == MD_ITER_DIV) begin
         add_x   = acc[2*XLEN-1:XLEN-1];
         add_y   = ~{1'b0, b_q};
         add_cin = 1'b1;
      end else begin
         add_x   = {1'b0, acc[2*XLEN-1:XLEN]};
         add_y   = acc[0] ? {1'b0, b_q} : '0;
         add_cin = 1'b0;
      end
   end

   assign add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};
   assign no_borrow = add_sum[XLEN+1];

   always_comb begin
      case (state)
         MD_ITER_MUL: acc_next = {add_sum[XLEN:0], acc[XLEN-1:1]};
         MD_ITER_DIV: acc_next = {no_borrow ? add_sum[XLEN-1:0] : add_x[XLEN-1:0],
                                  acc[XLEN-2:0], no_borrow};
         default:     acc_next = acc;
      endcase
   end

   always_comb begin
      if (!op_q[2])
         fix_in = acc_next;
      else if (op_q[1])
         fix_in = {{XLEN{1'b0}}, acc_next[2*XLEN-1:XLEN]};
      else
         fix_in = {{XLEN{1'b0}}, acc_next[XLEN-1:0]};
   end

   cond_negate #(.WIDTH(2*XLEN)) u_fix (.x(fix_in), .neg(neg_q), .y(fix_out));

   assign iter_res = (!op_q[2] && op_q[1:0] != 2'd0) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= MD_IDLE;
         op_q        <= MD_MUL;
         neg_q       <= 1'b0;
         b_q         <= '0;
         acc         <= '0;
         cnt         <= '0;
         E_md_result <= '0;
      end else if (E_md_flush) begin
         state <= MD_IDLE;
      end else begin
         case (state)
            MD_IDLE: begin
               if (accept) begin
                  op_q  <= md_op_t'(E_md_op);
                  neg_q <= neg_in;
                  b_q   <= abs_b;
                  acc   <= {{XLEN{1'b0}}, abs_a};
                  cnt   <= '0;
                  if (special) begin
                     E_md_result <= special_res;
                     state       <= MD_DONE;
                  end else begin
                     state <= E_md_op[2] ? MD_ITER_DIV : MD_ITER_MUL;
                  end
               end
            end
            MD_ITER_MUL, MD_ITER_DIV: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) begin
                  E_md_result <= iter_res;
                  state       <= MD_DONE;
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

   assign E_md_stall = accept || (state == MD_ITER_MUL) || (state == MD_ITER_DIV);
   assign E_md_done  = (state == MD_DONE);

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb/tb_execute_muldiv_unit.sv - directed self-checking bench for execute_muldiv_unit at XLEN 32 and 64
module tb_execute_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [2:0]  op;
   logic [63:0] src_a, src_b;
   logic        stall32, done32, stall64, done64;
   logic [31:0] res32;
   logic [63:0] res64;
   int          checks = 0;
   int          failures = 0;
   int          done_seen;

   always #5 clk = ~clk;

   execute_muldiv_unit #(.XLEN(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .E_md_start(start), .E_md_op(op),
      .E_md_src_a(src_a[31:0]), .E_md_src_b(src_b[31:0]), .E_md_flush(flush),
      .E_md_stall(stall32), .E_md_done(done32), .E_md_result(res32)
   );

   execute_muldiv_unit #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .E_md_start(start), .E_md_op(op),
      .E_md_src_a(src_a), .E_md_src_b(src_b), .E_md_flush(flush),
      .E_md_stall(stall64), .E_md_done(done64), .E_md_result(res64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one op from cycle 0 and checks stall profile, latency, result and single-cycle done.
   task automatic run_op(input bit w64, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input string tag);
      int   cyc;
      int   stall_bad;
      logic d, s;
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      #1 s = w64 ? stall64 : stall32;
      check({tag, ":stall_c0"}, 64'(s), 64'd1);
      cyc = 0; stall_bad = 0; d = 1'b0;
      while (!d && cyc < 80) begin
         @(negedge clk);
         cyc++;
         d = w64 ? done64 : done32;
         s = w64 ? stall64 : stall32;
         if (s !== !d) stall_bad++;
      end
      start = 1'b0;
      check({tag, ":latency"}, 64'(cyc), 64'(lat));
      check({tag, ":result"}, w64 ? res64 : {32'd0, res32}, exp);
      check({tag, ":stall_profile"}, 64'(stall_bad), 64'd0);
      @(negedge clk);
      d = w64 ? done64 : done32;
      check({tag, ":done_pulse"}, 64'(d), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
      #1;
      check("rst:stall32", 64'(stall32), 64'd0);
      check("rst:done32", 64'(done32), 64'd0);
      check("rst:res32", 64'(res32), 64'd0);
      check("rst:stall64", 64'(stall64), 64'd0);
      check("rst:done64", 64'(done64), 64'd0);
      check("rst:res64", res64, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 3'd0, 64'h0000_0007, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, "mul_7xm3");
      run_op(1'b0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "mulh_min_sq");
      run_op(1'b0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 33, "mulhsu_ones");
      run_op(1'b0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "mulhu_ones");
      run_op(1'b0, 3'd4, 64'hFFFF_FFF9, 64'h0000_0002, 64'hFFFF_FFFD, 33, "div_m7_2");
      run_op(1'b0, 3'd6, 64'hFFFF_FFF9, 64'h0000_0002, 64'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(1'b0, 3'd5, 64'd100, 64'd7, 64'd14, 33, "divu_100_7");
      run_op(1'b0, 3'd7, 64'd100, 64'd7, 64'd2, 33, "remu_100_7");
      run_op(1'b0, 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF, 1, "divu_by0");
      run_op(1'b0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div_ovf");
      run_op(1'b0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, "rem_ovf");
      run_op(1'b0, 3'd7, 64'd5, 64'd0, 64'd5, 1, "remu_by0");

      // Flush a DIV in cycle 10: no done, result keeps the REMU-by-zero value.
      @(negedge clk);
      op = 3'd5; src_a = 64'd100; src_b = 64'd7; start = 1'b1;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      #1;
      check("flush:stall", 64'(stall32), 64'd0);
      check("flush:done", 64'(done32), 64'd0);
      check("flush:result_held", 64'(res32), 64'd5);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32) done_seen++;
      end
      check("flush:no_done", 64'(done_seen), 64'd0);
      run_op(1'b0, 3'd0, 64'd3, 64'd4, 64'd12, 33, "mul_3x4_after_flush");

      // Asynchronous reset in cycle 5 of a MUL.
      @(negedge clk);
      op = 3'd0; src_a = 64'h1234; src_b = 64'd5; start = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0; start = 1'b0;
      #1;
      check("arst:stall", 64'(stall32), 64'd0);
      check("arst:done", 64'(done32), 64'd0);
      check("arst:result", 64'(res32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 3'd5, 64'd9, 64'd3, 64'd3, 33, "divu_9_3_after_rst");

      repeat (70) @(negedge clk);
      run_op(1'b1, 3'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65, "x64_mulhu");
      run_op(1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "x64_div_m7_2");
      run_op(1'b1, 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "x64_divu_by0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
